// File: rtl/fetch_stage_ifid.sv
// Instruction-fetch stage: owns the PC, feeds the instruction memory address and
// captures the returned instruction into the IF/ID register (stall, redirect, halt).
module fetch_stage_ifid #(
  parameter int unsigned IMEM_BYTES = 32,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_en,
  input  logic [31:0]      redirect_pc,
  input  logic [31:0]      Instruction_Code,
  output logic [31:0]      PC,
  output logic [31:0]      IFID_Instr,
  output logic [31:0]      IFID_PC4,
  output logic             IFID_valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

  state_t             state_q, state_d;
  logic [31:0]        pc_d, instr_d, pc4_d;
  logic               valid_d;
  logic [CNT_W-1:0]   count_d;
  logic [31:0]        pc_plus4;
  logic               out_of_range;
  logic               unused_redirect_lsbs;

  assign pc_plus4             = PC + 32'd4;
  assign out_of_range         = (PC > LAST_PC);
  // Byte-offset bits of a redirect target are dropped to keep the PC word-aligned.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign halted               = (state_q == HALT);

  always_comb begin
    // NOTE: every next-value is first defaulted to "hold"; any branch that skips an
    // assignment then keeps the register value instead of inferring a latch.
    state_d = state_q;
    pc_d    = PC;
    instr_d = IFID_Instr;
    pc4_d   = IFID_PC4;
    valid_d = IFID_valid;
    count_d = fetch_count;

    if (redirect_en) begin
      // Redirect wins in either state and flushes whatever IF/ID holds.
      state_d = RUN;
      pc_d    = {redirect_pc[31:2], 2'b00};
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (out_of_range) begin
            state_d = HALT;
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
          end else if (!stall) begin
            pc_d    = pc_plus4;
            instr_d = Instruction_Code;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            count_d = fetch_count + CNT_W'(1);
          end
        end
        HALT: begin
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= RUN;
      PC          <= RESET_PC;
      IFID_Instr  <= '0;
      IFID_PC4    <= '0;
      IFID_valid  <= 1'b0;
      fetch_count <= '0;
    end else begin
      state_q     <= state_d;
      PC          <= pc_d;
      IFID_Instr  <= instr_d;
      IFID_PC4    <= pc4_d;
      IFID_valid  <= valid_d;
      fetch_count <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage_ifid.sv
// Self-checking bench for fetch_stage_ifid: directed scenarios followed by random
// stall/redirect/reset traffic, all compared against a cycle-level reference model.
module tb_fetch_stage_ifid;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] instr_code;
  logic [31:0] pc, ifid_instr, ifid_pc4;
  logic        ifid_valid, halted;
  logic [15:0] fetch_count;

  // Narrow-counter copy sharing all inputs, so counter wrap-around is reached quickly.
  logic [31:0] pc_w, ifid_instr_w, ifid_pc4_w;
  logic        ifid_valid_w, halted_w;
  logic [3:0]  fetch_count_w;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [31:0] imem [8] = '{32'h8C010000, 32'h00201020, 32'h00411022, 32'h08400005,
                            32'h00411820, 32'h00412020, 32'hACA10000, 32'h00000000};

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_halt;
  int unsigned m_count;

  always #5 clk = ~clk;

  fetch_stage_ifid dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .Instruction_Code(instr_code),
    .PC(pc), .IFID_Instr(ifid_instr), .IFID_PC4(ifid_pc4),
    .IFID_valid(ifid_valid), .halted(halted), .fetch_count(fetch_count)
  );

  fetch_stage_ifid #(.CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .Instruction_Code(instr_code),
    .PC(pc_w), .IFID_Instr(ifid_instr_w), .IFID_PC4(ifid_pc4_w),
    .IFID_valid(ifid_valid_w), .halted(halted_w), .fetch_count(fetch_count_w)
  );

  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    if (addr < 32'd32) return imem[addr[4:2]];
    return 32'h0;
  endfunction

  always_comb instr_code = imem_word(pc);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    check("pc",          pc,                      m_pc);
    check("ifid_instr",  ifid_instr,              m_instr);
    check("ifid_pc4",    ifid_pc4,                m_pc4);
    check("ifid_valid",  32'(ifid_valid),         32'(m_valid));
    check("halted",      32'(halted),             32'(m_halt));
    check("fetch_count", 32'(fetch_count),        m_count % 65536);
    check("count_w",     32'(fetch_count_w),      m_count % 16);
    check("pc_w",        pc_w,                    m_pc);
  endtask

  // One clock edge: model decides from pre-edge state/inputs, then DUT is compared.
  task automatic step();
    logic [31:0] n_pc, n_instr, n_pc4;
    logic        n_valid, n_halt;
    int unsigned n_count;
    n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4;
    n_valid = m_valid; n_halt = m_halt; n_count = m_count;
    if (reset) begin
      n_pc = 32'h0; n_instr = 32'h0; n_pc4 = 32'h0;
      n_valid = 1'b0; n_halt = 1'b0; n_count = 0;
    end else if (redirect_en) begin
      n_pc = redirect_pc & 32'hFFFF_FFFC;
      n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0; n_halt = 1'b0;
    end else if (m_halt || m_pc > 32'd28) begin
      n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0; n_halt = 1'b1;
    end else if (!stall) begin
      n_instr = imem_word(m_pc);
      n_pc4   = m_pc + 32'd4;
      n_pc    = m_pc + 32'd4;
      n_valid = 1'b1;
      n_count = m_count + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4;
    m_valid = n_valid; m_halt = n_halt; m_count = n_count;
    check_all();
  endtask

  task automatic drive(input logic rst, input logic stl, input logic red, input logic [31:0] rpc);
    reset = rst; stall = stl; redirect_en = red; redirect_pc = rpc;
  endtask

  initial begin
    m_pc = '0; m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_halt = 1'b0; m_count = 0;
    drive(1'b1, 1'b1, 1'b1, 32'h10);
    #2;

    // Reset dominates stall and redirect
    step(); step();
    check("rst_pc", pc, 32'h0);
    check("rst_count", 32'(fetch_count), 32'h0);

    // Sequential fetch
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("seq1_instr", ifid_instr, 32'h8C010000);
    check("seq1_pc4", ifid_pc4, 32'h4);
    step();
    check("seq2_instr", ifid_instr, 32'h00201020);
    check("seq2_pc", pc, 32'h8);

    // Stall holds PC, IF/ID and count
    stall = 1'b1;
    step(); step();
    check("stall_pc", pc, 32'h8);
    check("stall_count", 32'(fetch_count), 32'd2);
    stall = 1'b0;
    step();
    check("unstall_instr", ifid_instr, 32'h00411022);
    step();

    // Redirect beats stall; low target bits discarded
    drive(1'b0, 1'b1, 1'b1, 32'h16);
    step();
    check("redir_pc", pc, 32'h14);
    check("redir_valid", 32'(ifid_valid), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("redir_next_instr", ifid_instr, 32'h00412020);

    // Run off the end of memory into HALT, then redirect out of it
    step(); step();
    check("end_pc", pc, 32'h20);
    step();
    check("halt_flag", 32'(halted), 32'h1);
    check("halt_pc", pc, 32'h20);
    stall = 1'b1;
    step();
    check("halt_hold_pc", pc, 32'h20);
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    step();
    check("unhalt_flag", 32'(halted), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("unhalt_instr", ifid_instr, 32'h8C010000);

    // Reset mid-stream
    step(); step();
    check("mid_pc", pc, 32'hC);
    reset = 1'b1;
    step();
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_valid", 32'(ifid_valid), 32'h0);
    reset = 1'b0;

    // Random traffic; the 4-bit counter copy wraps many times here
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 15) == 0),
            32'($urandom_range(0, 47)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
